jtkicker_gfx_arb: RTL and testbench

// Shares the single 32-bit graphics SDRAM read slot between the scroll tile fetcher and the object (sprite) fetcher.

---
 rtl/jtkicker_gfx_arb_pkg.sv | 12 +
 rtl/jtkicker_gfx_arb_if.sv | 30 +++
 rtl/jtkicker_gfx_arb_slot.sv | 49 ++++
 rtl/jtkicker_gfx_arb.sv | 120 ++++++++++++
 tb/tb_jtkicker_gfx_arb.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtkicker_gfx_arb_pkg.sv
// Shared types for the graphics SDRAM read-slot arbiter: FSM encoding and requester indices.
// No logic; imported by the arbiter, its interface users and the per-requester slot.
package jtkicker_gfx_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic GNT_SCR = 1'b0;
   localparam logic GNT_OBJ = 1'b1;
endpackage

// File: rtl/jtkicker_gfx_arb_if.sv
// Requester and SDRAM-port bundle for jtkicker_gfx_arb; slave = arbiter side, master = surroundings.
// sd_req is held until sd_ack; each requester sees its word through a combinational ok flag.
interface jtkicker_gfx_arb_if #(
   parameter int SCR_AW = 13,
   parameter int OBJ_AW = 14,
   parameter int SDW    = 22
) ();
   logic              scr_cs;
   logic [SCR_AW-1:0] scr_addr;
   logic [31:0]       scr_data;
   logic              scr_ok;
   logic              obj_cs;
   logic [OBJ_AW-1:0] obj_addr;
   logic [31:0]       obj_data;
   logic              obj_ok;
   logic [SDW-1:0]    sd_addr;
   logic              sd_req;
   logic              sd_ack;
   logic              sd_dok;
   logic [31:0]       sd_data;

   modport slave (
      input  scr_cs, scr_addr, obj_cs, obj_addr, sd_ack, sd_dok, sd_data,
      output scr_data, scr_ok, obj_data, obj_ok, sd_addr, sd_req
   );
   modport master (
      output scr_cs, scr_addr, obj_cs, obj_addr, sd_ack, sd_dok, sd_data,
      input  scr_data, scr_ok, obj_data, obj_ok, sd_addr, sd_req
   );
endinterface

// File: rtl/jtkicker_gfx_arb_slot.sv
// One-word cache per requester: tag/valid/data, hit compare and ok flag.
// ok/miss are combinational on addr; the word is written the cycle the fetch completes.
module jtkicker_gfx_arb_slot #(
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          wr,
   input  logic [AW-1:0] wr_tag,
   input  logic [31:0]   wr_data,
   output logic [31:0]   data,
   output logic          ok,
   output logic          miss
);
   logic [AW-1:0] tag_q, tag_d;
   logic          val_q, val_d;
   logic [31:0]   data_q, data_d;
   logic          hit;

   always_comb begin
      tag_d  = tag_q;
      val_d  = val_q;
      data_d = data_q;
      if (wr) begin
         tag_d  = wr_tag;
         val_d  = 1'b1;
         data_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q  <= '0;
         val_q  <= 1'b0;
         data_q <= '0;
      end else begin
         tag_q  <= tag_d;
         val_q  <= val_d;
         data_q <= data_d;
      end
   end

   assign hit  = val_q && (addr == tag_q);
   assign ok   = cs && hit;
   assign miss = cs && !hit;
   assign data = data_q;
endmodule

// File: rtl/jtkicker_gfx_arb.sv
// Shares one SDRAM read slot between scroll and object fetchers; min miss latency 2 cycles, one fetch in flight.
// Fixed scroll priority with starvation override; `JTKICKER_GFXARB_RR_EN selects round-robin instead.
module jtkicker_gfx_arb
   import jtkicker_gfx_arb_pkg::*;
#(
   parameter int             SCR_AW  = 13,
   parameter int             OBJ_AW  = 14,
   parameter int             SDW     = 22,
   parameter logic [SDW-1:0] SCR_OFS = '0,
   parameter logic [SDW-1:0] OBJ_OFS = SDW'(32'h2000),
   parameter int             STARVE  = 16
) (
   input logic                clk,
   input logic                rst_n,
   jtkicker_gfx_arb_if.slave  bus
);
   localparam int RAW = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic [RAW-1:0] req_addr_q, req_addr_d;
   logic [SDW-1:0] sd_addr_q, sd_addr_d;
   logic           sd_req_q, sd_req_d;
   logic           scr_miss, obj_miss, done, win;

   assign done = (state_q == ST_REQ && bus.sd_ack && bus.sd_dok) ||
                 (state_q == ST_WAIT && bus.sd_dok);

   jtkicker_gfx_arb_slot #(.AW(SCR_AW)) u_scr (
      .clk(clk), .rst_n(rst_n), .cs(bus.scr_cs), .addr(bus.scr_addr),
      .wr(done && gnt_q == GNT_SCR), .wr_tag(SCR_AW'(req_addr_q)), .wr_data(bus.sd_data),
      .data(bus.scr_data), .ok(bus.scr_ok), .miss(scr_miss)
   );

   jtkicker_gfx_arb_slot #(.AW(OBJ_AW)) u_obj (
      .clk(clk), .rst_n(rst_n), .cs(bus.obj_cs), .addr(bus.obj_addr),
      .wr(done && gnt_q == GNT_OBJ), .wr_tag(OBJ_AW'(req_addr_q)), .wr_data(bus.sd_data),
      .data(bus.obj_data), .ok(bus.obj_ok), .miss(obj_miss)
   );

`ifdef JTKICKER_GFXARB_RR_EN
   // gnt_q doubles as "granted last", so a tie goes to the other requester.
   assign win = (scr_miss && obj_miss) ? ~gnt_q : obj_miss;
`else
   localparam int STARVE_W = $clog2(STARVE + 1);
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                starved;

   assign starved = (starve_q == STARVE_W'(STARVE));
   assign win     = obj_miss && (!scr_miss || starved);

   // Held at zero while the object's own fetch is in flight.
   always_comb begin
      starve_d = starve_q;
      if (!obj_miss || (state_q == ST_IDLE && win == GNT_OBJ))
         starve_d = '0;
      else if (!(state_q != ST_IDLE && gnt_q == GNT_OBJ) && !starved)
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      req_addr_d = req_addr_q;
      sd_addr_d  = sd_addr_q;
      sd_req_d   = sd_req_q;
      unique case (state_q)
         ST_IDLE: begin
            if (scr_miss || obj_miss) begin
               gnt_d    = win;
               sd_req_d = 1'b1;
               state_d  = ST_REQ;
               if (win == GNT_OBJ) begin
                  req_addr_d = RAW'(bus.obj_addr);
                  sd_addr_d  = SDW'(bus.obj_addr) + OBJ_OFS;
               end else begin
                  req_addr_d = RAW'(bus.scr_addr);
                  sd_addr_d  = SDW'(bus.scr_addr) + SCR_OFS;
               end
            end
         end
         ST_REQ: begin
            if (bus.sd_ack) begin
               sd_req_d = 1'b0;
               state_d  = bus.sd_dok ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.sd_dok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Resetting gnt_q to the object side makes the first round-robin tie go to scroll.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= GNT_OBJ;
         req_addr_q <= '0;
         sd_addr_q  <= '0;
         sd_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         req_addr_q <= req_addr_d;
         sd_addr_q  <= sd_addr_d;
         sd_req_q   <= sd_req_d;
      end
   end

   assign bus.sd_addr = sd_addr_q;
   assign bus.sd_req  = sd_req_q;
endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
// Bench for jtkicker_gfx_arb: SDRAM model with programmable ack/dok timing and an
// expected-address scoreboard popped on every accepted request.
module tb_jtkicker_gfx_arb;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   jtkicker_gfx_arb_if #(.SCR_AW(13), .OBJ_AW(14), .SDW(22)) bus ();

   jtkicker_gfx_arb #(
      .SCR_AW(13), .OBJ_AW(14), .SDW(22),
      .SCR_OFS(22'h0), .OBJ_OFS(22'h2000), .STARVE(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [21:0] a);
      return 32'hDEADBEEF ^ {10'd0, a ^ 22'h10};
   endfunction

   // SDRAM model and scoreboard
   int          lat   = 4;
   int          gap   = 0;
   int          n_ack = 0;
   int          n_dok = 0;
   bit          sb_en = 1'b1;
   logic [21:0] exp_q[$];
   bit          glog[$];
   logic [21:0] held_addr;

   initial begin
      int cnt, dok_wait;
      cnt = 0; dok_wait = 0;
      bus.sd_ack = 1'b0; bus.sd_dok = 1'b0; bus.sd_data = '0;
      held_addr = '0;
      forever begin
         @(posedge clk); #1;
         bus.sd_ack = 1'b0;
         bus.sd_dok = 1'b0;
         if (dok_wait > 0) begin
            dok_wait--;
            if (dok_wait == 0) begin
               bus.sd_dok  = 1'b1;
               bus.sd_data = data_of(held_addr);
               n_dok++;
            end
         end else if (bus.sd_req) begin
            cnt++;
            if (cnt >= lat) begin
               cnt = 0;
               held_addr  = bus.sd_addr;
               bus.sd_ack = 1'b1;
               n_ack++;
               glog.push_back(held_addr >= 22'h2000);
               if (sb_en) begin
                  if (exp_q.size() == 0) check("sb_unexpected_req", held_addr, 64'hFFFF_FFFF);
                  else                   check("sb_sd_addr", held_addr, exp_q.pop_front());
               end
               if (gap == 0) begin
                  bus.sd_dok  = 1'b1;
                  bus.sd_data = data_of(held_addr);
                  n_dok++;
               end else begin
                  dok_wait = gap;
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic wait_ok(input bit obj, input int maxc, output bit got);
      got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         @(posedge clk); #1;
         got = obj ? bus.obj_ok : bus.scr_ok;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int a0, d0, n;
      rst_n = 1'b0;
      bus.scr_cs = 1'b1; bus.scr_addr = 13'h010;
      bus.obj_cs = 1'b0; bus.obj_addr = '0;

      // Reset state, then first scroll miss
      repeat (3) @(posedge clk);
      #1;
      check("rst_sd_req", bus.sd_req, 0);
      check("rst_sd_addr", bus.sd_addr, 0);
      check("rst_scr_ok", bus.scr_ok, 0);
      check("rst_obj_ok", bus.obj_ok, 0);
      check("rst_scr_data", bus.scr_data, 0);
      exp_q.push_back(22'h10);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t1_req", bus.sd_req, 1);
      check("t1_sd_addr", bus.sd_addr, 22'h10);
      wait_ok(1'b0, 20, got);
      check("t1_scr_ok", got, 1);
      check("t1_scr_data", bus.scr_data, 32'hDEADBEEF);
      a0 = n_ack;
      repeat (10) @(posedge clk);
      #1;
      check("t1_no_refetch", n_ack - a0, 0);
      check("t1_req_idle", bus.sd_req, 0);

`ifndef JTKICKER_GFXARB_RR_EN
      // Simultaneous misses: scroll first
      lat = 2;
      bus.scr_addr = 13'h001;
      bus.obj_cs = 1'b1; bus.obj_addr = 14'h002;
      exp_q.push_back(22'h1);
      exp_q.push_back(22'h2002);
      wait_ok(1'b0, 20, got);
      check("t2_scr_ok", got, 1);
      check("t2_obj_not_yet", bus.obj_ok, 0);
      check("t2_scr_data", bus.scr_data, data_of(22'h1));
      wait_ok(1'b1, 20, got);
      check("t2_obj_ok", got, 1);
      check("t2_obj_data", bus.obj_data, data_of(22'h2002));

      // Starvation override under continuous scroll misses
      lat = 1; sb_en = 1'b0;
      a0 = n_ack;
      bus.scr_addr = 13'h100; bus.obj_addr = 14'h003;
      n = 0; got = 1'b0;
      while (n < 60 && !got) begin
         @(posedge clk); #1;
         n++;
         if (bus.obj_ok) got = 1'b1;
         else if (bus.scr_ok) bus.scr_addr = bus.scr_addr + 13'd1;
      end
      check("t3_obj_ok", got, 1);
      check("t3_latency", n, 18);
      check("t3_within_bound", (n >= 16 && n <= 16 + 2 * 2), 1);
      check("t3_fetches", n_ack - a0, 9);
      check("t3_obj_data", bus.obj_data, data_of(22'h2003));
      wait_ok(1'b0, 20, got);
      check("t3_scr_settle", got, 1);
      repeat (2) @(posedge clk);
      sb_en = 1'b1;
`endif

      // Address moves while the fetch is in WAIT
      @(posedge clk); #1;
      lat = 2; gap = 3;
      a0 = n_ack; d0 = n_dok;
      bus.scr_addr = 13'h020;
      exp_q.push_back(22'h20);
      exp_q.push_back(22'h21);
      for (int i = 0; i < 20 && n_ack == a0; i++) begin
         @(posedge clk); #1;
      end
      check("t4_acked", n_ack - a0, 1);
      bus.scr_addr = 13'h021;
      wait_ok(1'b0, 40, got);
      check("t4_scr_ok", got, 1);
      check("t4_ok_after_refetch", n_dok - d0, 2);
      check("t4_scr_data", bus.scr_data, data_of(22'h21));

      // Reset during WAIT; the late dok must be ignored
      lat = 1; gap = 6;
      a0 = n_ack; d0 = n_dok;
      bus.scr_addr = 13'h030;
      exp_q.push_back(22'h30);
      for (int i = 0; i < 20 && n_ack == a0; i++) begin
         @(posedge clk); #1;
      end
      check("t5_acked", n_ack - a0, 1);
      bus.scr_cs = 1'b0; bus.obj_cs = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("t5_late_dok_sent", n_dok - d0, 1);
      check("t5_req_low", bus.sd_req, 0);
      check("t5_scr_data", bus.scr_data, 0);
      check("t5_obj_data", bus.obj_data, 0);
      gap = 0;
      bus.scr_cs = 1'b1; bus.obj_cs = 1'b1;
      exp_q.push_back(22'h30);
      exp_q.push_back(22'h2000 + 22'(bus.obj_addr));
      @(posedge clk); #1;
      check("t5_regrant", bus.sd_req, 1);
      check("t5_scr_ok_low", bus.scr_ok, 0);
      wait_ok(1'b0, 20, got);
      check("t5_scr_ok", got, 1);
      check("t5_scr_data2", bus.scr_data, data_of(22'h30));
      wait_ok(1'b1, 20, got);
      check("t5_obj_ok", got, 1);

`ifdef JTKICKER_GFXARB_RR_EN
      // Round-robin under continuous misses on both sides
      sb_en = 1'b0; lat = 1;
      glog.delete();
      bus.scr_addr = 13'h200; bus.obj_addr = 14'h400;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.scr_ok) bus.scr_addr = bus.scr_addr + 13'd1;
         if (bus.obj_ok) bus.obj_addr = bus.obj_addr + 14'd1;
      end
      check("t6_grants", glog.size() >= 6, 1);
      check("t6_first_scr", glog[0], 0);
      for (int i = 1; i < 6; i++) check("t6_alternate", glog[i], !glog[i-1]);
      bus.scr_cs = 1'b0; bus.obj_cs = 1'b0;
      repeat (10) @(posedge clk);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
